// File: rtl/sdram_pro_arbit.sv
// SDRAM command arbiter: init owns the bus until init_end, then refresh > write > read.
// Optional `ARBIT_RR_WR_RD_EN` alternates write/read when both are pending.
module sdram_pro_arbit #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [1:0]        init_bank,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic [1:0]        aref_bank,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [1:0]        wr_bank,
  input  logic              wr_sdram_en,
  input  logic [DATA_W-1:0] wr_sdram_data,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [1:0]        rd_bank,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic [3:0]        sdram_cmd,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [1:0]        sdram_ba,
  output logic [DATA_W-1:0] sdram_dq_out,
  output logic              sdram_dq_oe
);

  localparam logic [2:0] INIT  = 3'd0;
  localparam logic [2:0] ARBIT = 3'd1;
  localparam logic [2:0] AREF  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] READ  = 3'd4;

  localparam logic [3:0] CMD_NOP = 4'b0111;

  logic [2:0]        state_q, state_d;
  logic [3:0]        cmd_d;
  logic [ADDR_W-1:0] addr_d;
  logic [1:0]        ba_d;

`ifdef ARBIT_RR_WR_RD_EN
  logic last_wr_q, last_wr_d;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT:  if (init_end) state_d = ARBIT;
      ARBIT: begin
        if (aref_req) begin
          state_d = AREF;
        end else if (wr_req && rd_req) begin
`ifdef ARBIT_RR_WR_RD_EN
          state_d = last_wr_q ? READ : WRITE;
`else
          state_d = WRITE;
`endif
        end else if (wr_req) begin
          state_d = WRITE;
        end else if (rd_req) begin
          state_d = READ;
        end
      end
      AREF:  if (aref_end) state_d = ARBIT;
      WRITE: if (wr_end) state_d = ARBIT;
      READ:  if (rd_end) state_d = ARBIT;
      default: state_d = INIT;
    endcase
  end

`ifdef ARBIT_RR_WR_RD_EN
  always_comb begin
    last_wr_d = last_wr_q;
    if (state_q == ARBIT && state_d == WRITE) last_wr_d = 1'b1;
    if (state_q == ARBIT && state_d == READ)  last_wr_d = 1'b0;
  end
`endif

  // Pin mux follows the current owner; the register stage adds the one-cycle latency.
  always_comb begin
    cmd_d  = CMD_NOP;
    addr_d = '1;
    ba_d   = 2'b11;
    case (state_q)
      INIT: begin
        cmd_d  = init_cmd;
        addr_d = init_addr;
        ba_d   = init_bank;
      end
      AREF: begin
        cmd_d  = aref_cmd;
        addr_d = aref_addr;
        ba_d   = aref_bank;
      end
      WRITE: begin
        cmd_d  = wr_cmd;
        addr_d = wr_addr;
        ba_d   = wr_bank;
      end
      READ: begin
        cmd_d  = rd_cmd;
        addr_d = rd_addr;
        ba_d   = rd_bank;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= INIT;
      sdram_cmd    <= CMD_NOP;
      sdram_addr   <= '1;
      sdram_ba     <= 2'b11;
      sdram_dq_out <= '0;
      sdram_dq_oe  <= 1'b0;
`ifdef ARBIT_RR_WR_RD_EN
      last_wr_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sdram_cmd  <= cmd_d;
      sdram_addr <= addr_d;
      sdram_ba   <= ba_d;
      if (state_q == WRITE) begin
        sdram_dq_out <= wr_sdram_data;
        sdram_dq_oe  <= wr_sdram_en;
      end else begin
        sdram_dq_oe  <= 1'b0;
      end
`ifdef ARBIT_RR_WR_RD_EN
      last_wr_q <= last_wr_d;
`endif
    end
  end

  assign aref_en   = (state_q == AREF);
  assign wr_en     = (state_q == WRITE);
  assign rd_en     = (state_q == READ);
  assign sdram_cke = 1'b1;

endmodule

// File: tb/tb_sdram_pro_arbit.sv
// Self-checking bench for sdram_pro_arbit: directed scenarios plus random traffic vs. an owner model.
module tb_sdram_pro_arbit;

  logic        sys_clk, sys_rst, init_end;
  logic [3:0]  init_cmd, aref_cmd, wr_cmd, rd_cmd;
  logic [11:0] init_addr, aref_addr, wr_addr, rd_addr;
  logic [1:0]  init_bank, aref_bank, wr_bank, rd_bank;
  logic        aref_req, aref_end, wr_req, wr_end, rd_req, rd_end;
  logic        wr_sdram_en;
  logic [15:0] wr_sdram_data;
  logic        aref_en, wr_en, rd_en, sdram_cke, sdram_dq_oe;
  logic [3:0]  sdram_cmd;
  logic [11:0] sdram_addr;
  logic [1:0]  sdram_ba;
  logic [15:0] sdram_dq_out;

  int n_vec = 0;
  int n_err = 0;

  sdram_pro_arbit #(.DATA_W(16), .ADDR_W(12)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end),
    .init_cmd(init_cmd), .init_addr(init_addr), .init_bank(init_bank),
    .aref_req(aref_req), .aref_end(aref_end),
    .aref_cmd(aref_cmd), .aref_addr(aref_addr), .aref_bank(aref_bank),
    .wr_req(wr_req), .wr_end(wr_end),
    .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank),
    .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
    .rd_req(rd_req), .rd_end(rd_end),
    .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en), .sdram_cke(sdram_cke),
    .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_ba(sdram_ba),
    .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Reference model: tracks who owns the bus and what the pins must show.
  localparam int OWN_INIT = 0, OWN_NONE = 1, OWN_AREF = 2, OWN_WR = 3, OWN_RD = 4;
  int          m_owner = OWN_INIT;
  logic        m_last_wr = 1'b0;
  logic [3:0]  m_cmd = 4'b0111;
  logic [11:0] m_addr = 12'hfff;
  logic [1:0]  m_ba = 2'b11;
  logic [15:0] m_dq = 16'h0;
  logic        m_oe = 1'b0;

  always @(posedge sys_clk) begin
    if (sys_rst) begin
      m_owner = OWN_INIT; m_last_wr = 1'b0;
      m_cmd = 4'b0111; m_addr = 12'hfff; m_ba = 2'b11; m_dq = 16'h0; m_oe = 1'b0;
    end else begin
      m_oe = 1'b0;
      if (m_owner == OWN_INIT) begin
        m_cmd = init_cmd; m_addr = init_addr; m_ba = init_bank;
        if (init_end) m_owner = OWN_NONE;
      end else if (m_owner == OWN_AREF) begin
        m_cmd = aref_cmd; m_addr = aref_addr; m_ba = aref_bank;
        if (aref_end) m_owner = OWN_NONE;
      end else if (m_owner == OWN_WR) begin
        m_cmd = wr_cmd; m_addr = wr_addr; m_ba = wr_bank;
        m_dq = wr_sdram_data; m_oe = wr_sdram_en;
        if (wr_end) m_owner = OWN_NONE;
      end else if (m_owner == OWN_RD) begin
        m_cmd = rd_cmd; m_addr = rd_addr; m_ba = rd_bank;
        if (rd_end) m_owner = OWN_NONE;
      end else begin
        m_cmd = 4'b0111; m_addr = 12'hfff; m_ba = 2'b11;
        if (aref_req) m_owner = OWN_AREF;
        else if (wr_req && rd_req) begin
`ifdef ARBIT_RR_WR_RD_EN
          m_owner = m_last_wr ? OWN_RD : OWN_WR;
`else
          m_owner = OWN_WR;
`endif
        end
        else if (wr_req) m_owner = OWN_WR;
        else if (rd_req) m_owner = OWN_RD;
        if (m_owner == OWN_WR) m_last_wr = 1'b1;
        if (m_owner == OWN_RD) m_last_wr = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle_inputs();
    aref_req = 0; aref_end = 0; wr_req = 0; wr_end = 0; rd_req = 0; rd_end = 0;
    wr_sdram_en = 0;
  endtask

  task automatic do_init();
    sys_rst = 1; init_end = 0; idle_inputs();
    tick(); tick();
    sys_rst = 0; tick();
    init_end = 1; tick(); tick();
  endtask

  task automatic test_reset();
    sys_rst = 1; init_end = 0; idle_inputs();
    init_cmd = 4'b0010; init_addr = 12'h400; init_bank = 2'b00;
    aref_cmd = 4'b0001; wr_cmd = 4'b0100; rd_cmd = 4'b0101;
    aref_addr = 12'h0; wr_addr = 12'h0; rd_addr = 12'h0;
    aref_bank = 0; wr_bank = 0; rd_bank = 0; wr_sdram_data = 16'h0;
    tick(); tick(); tick();
    n_vec++;
    if ({sdram_cmd, sdram_addr, sdram_ba, sdram_dq_out, sdram_dq_oe, sdram_cke} !==
        {4'b0111, 12'hfff, 2'b11, 16'h0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_pins: got cmd=%b addr=%h ba=%b dq=%h oe=%b cke=%b, want 0111 fff 11 0000 0 1",
               sdram_cmd, sdram_addr, sdram_ba, sdram_dq_out, sdram_dq_oe, sdram_cke);
    end
    n_vec++;
    if ({aref_en, wr_en, rd_en} !== 3'b000) begin
      n_err++; $display("FAIL reset_grants: got %b want 000", {aref_en, wr_en, rd_en});
    end
    sys_rst = 0; wr_req = 1; aref_req = 1; wr_end = 1;
    tick();
    n_vec++;
    if (sdram_cmd !== 4'b0010) begin
      n_err++; $display("FAIL init_cmd_pass: got %b want 0010", sdram_cmd);
    end
    tick();
    n_vec++;
    if ({aref_en, wr_en, rd_en} !== 3'b000) begin
      n_err++; $display("FAIL init_ignores_req: got %b want 000", {aref_en, wr_en, rd_en});
    end
    idle_inputs(); init_end = 1;
    tick(); tick();
    n_vec++;
    if (sdram_cmd !== 4'b0111 || sdram_addr !== 12'hfff) begin
      n_err++; $display("FAIL arbit_nop: got cmd=%b addr=%h want 0111 fff", sdram_cmd, sdram_addr);
    end
  endtask

  task automatic test_single_write();
    wr_req = 1; tick();
    n_vec++;
    if (wr_en !== 1'b1) begin n_err++; $display("FAIL wr_grant: got %b want 1", wr_en); end
    wr_req = 0; wr_cmd = 4'b0100; wr_addr = 12'h055; wr_sdram_en = 1; wr_sdram_data = 16'h1234;
    tick();
    n_vec++;
    if ({sdram_cmd, sdram_addr, sdram_dq_oe, sdram_dq_out} !== {4'b0100, 12'h055, 1'b1, 16'h1234}) begin
      n_err++;
      $display("FAIL wr_data: got cmd=%b addr=%h oe=%b dq=%h want 0100 055 1 1234",
               sdram_cmd, sdram_addr, sdram_dq_oe, sdram_dq_out);
    end
    wr_sdram_en = 0; wr_end = 1; tick();
    n_vec++;
    if (wr_en !== 1'b0 || sdram_dq_oe !== 1'b0) begin
      n_err++; $display("FAIL wr_release: got wr_en=%b oe=%b want 0 0", wr_en, sdram_dq_oe);
    end
    wr_end = 0; wr_sdram_data = 16'hdead; tick();
    n_vec++;
    if (sdram_cmd !== 4'b0111 || sdram_dq_out !== 16'h1234) begin
      n_err++; $display("FAIL wr_after: got cmd=%b dq=%h want 0111 1234", sdram_cmd, sdram_dq_out);
    end
  endtask

  task automatic test_priority();
    logic first_wr;
`ifdef ARBIT_RR_WR_RD_EN
    first_wr = 1'b0;  // previous grant was a write
`else
    first_wr = 1'b1;
`endif
    aref_req = 1; wr_req = 1; rd_req = 1; aref_cmd = 4'b0001;
    tick();
    n_vec++;
    if ({aref_en, wr_en, rd_en} !== 3'b100) begin
      n_err++; $display("FAIL prio_aref: got %b want 100", {aref_en, wr_en, rd_en});
    end
    aref_req = 0; aref_end = 1; tick();
    n_vec++;
    if ({aref_en, wr_en, rd_en} !== 3'b000 || sdram_cmd !== 4'b0001) begin
      n_err++; $display("FAIL prio_aref_end: got grants=%b cmd=%b want 000 0001",
                        {aref_en, wr_en, rd_en}, sdram_cmd);
    end
    aref_end = 0; tick();
    n_vec++;
    if ({aref_en, wr_en, rd_en} !== (first_wr ? 3'b010 : 3'b001) || sdram_cmd !== 4'b0111) begin
      n_err++; $display("FAIL prio_second: got grants=%b cmd=%b want %b 0111",
                        {aref_en, wr_en, rd_en}, sdram_cmd, first_wr ? 3'b010 : 3'b001);
    end
    if (first_wr) begin wr_req = 0; wr_end = 1; end else begin rd_req = 0; rd_end = 1; end
    tick();
    wr_end = 0; rd_end = 0; tick();
    n_vec++;
    if ({aref_en, wr_en, rd_en} !== (first_wr ? 3'b001 : 3'b010) || sdram_cmd !== 4'b0111) begin
      n_err++; $display("FAIL prio_third: got grants=%b cmd=%b want %b 0111",
                        {aref_en, wr_en, rd_en}, sdram_cmd, first_wr ? 3'b001 : 3'b010);
    end
    wr_req = 0; rd_req = 0; wr_end = 1; rd_end = 1; tick();
    wr_end = 0; rd_end = 0; tick();
  endtask

  task automatic test_no_preempt();
    rd_req = 1; tick();
    rd_req = 0; aref_req = 1; rd_cmd = 4'b0101; rd_bank = 2'b10;
    for (int i = 0; i < 4; i++) begin
      rd_addr = 12'($urandom);
      tick();
      n_vec++;
      if ({aref_en, rd_en} !== 2'b01 || sdram_cmd !== 4'b0101 || sdram_addr !== rd_addr ||
          sdram_ba !== 2'b10) begin
        n_err++; $display("FAIL no_preempt[%0d]: got aref=%b rd=%b cmd=%b addr=%h want 0 1 0101 %h",
                          i, aref_en, rd_en, sdram_cmd, sdram_addr, rd_addr);
      end
    end
    rd_end = 1; tick();
    rd_end = 0;
    n_vec++;
    if ({aref_en, rd_en} !== 2'b00) begin
      n_err++; $display("FAIL rd_release: got %b want 00", {aref_en, rd_en});
    end
    tick();
    n_vec++;
    if (aref_en !== 1'b1) begin n_err++; $display("FAIL aref_after_rd: got %b want 1", aref_en); end
    aref_req = 0; aref_end = 1; tick();
    aref_end = 0; tick();
  endtask

  task automatic test_reset_mid_write();
    wr_req = 1; tick();
    wr_sdram_en = 1; wr_sdram_data = 16'habcd; tick();
    n_vec++;
    if (sdram_dq_oe !== 1'b1) begin n_err++; $display("FAIL rmw_oe_pre: got %b want 1", sdram_dq_oe); end
    sys_rst = 1; init_end = 0; tick();
    n_vec++;
    if (wr_en !== 1'b0 || sdram_dq_oe !== 1'b0 || sdram_cmd !== 4'b0111) begin
      n_err++; $display("FAIL rmw_reset: got wr_en=%b oe=%b cmd=%b want 0 0 0111",
                        wr_en, sdram_dq_oe, sdram_cmd);
    end
    sys_rst = 0; wr_sdram_en = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (wr_en !== 1'b0) begin n_err++; $display("FAIL rmw_init_wait[%0d]: got %b want 0", i, wr_en); end
    end
    init_end = 1; tick(); tick();
    n_vec++;
    if (wr_en !== 1'b1) begin n_err++; $display("FAIL rmw_regrant: got %b want 1", wr_en); end
    wr_req = 0; wr_end = 1; tick();
    wr_end = 0; tick();
  endtask

  task automatic test_wr_rd_alternation();
    int got [4];
    int want [4];
    int wait_cnt;
    do_init();
`ifdef ARBIT_RR_WR_RD_EN
    want = '{1, 2, 1, 2};
`else
    want = '{1, 1, 1, 1};
`endif
    wr_req = 1; rd_req = 1;
    for (int k = 0; k < 4; k++) begin
      wait_cnt = 0;
      while (!(wr_en || rd_en) && wait_cnt < 10) begin tick(); wait_cnt++; end
      got[k] = wr_en ? 1 : (rd_en ? 2 : 0);
      n_vec++;
      if (got[k] !== want[k]) begin
        n_err++; $display("FAIL alternation[%0d]: got grant %0d want %0d (1=W 2=R 0=timeout)",
                          k, got[k], want[k]);
      end
      tick();
      if (wr_en) wr_end = 1;
      if (rd_en) rd_end = 1;
      tick();
      wr_end = 0; rd_end = 0;
    end
    idle_inputs(); tick(); tick(); tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      sys_rst = ($urandom_range(0, 79) == 0);
      init_end = ($urandom_range(0, 5) != 0);
      aref_req = ($urandom_range(0, 3) == 0);
      wr_req = $urandom_range(0, 1); rd_req = $urandom_range(0, 1);
      aref_end = ($urandom_range(0, 3) == 0);
      wr_end = ($urandom_range(0, 3) == 0);
      rd_end = ($urandom_range(0, 3) == 0);
      init_cmd = 4'($urandom); aref_cmd = 4'($urandom); wr_cmd = 4'($urandom); rd_cmd = 4'($urandom);
      init_addr = 12'($urandom); aref_addr = 12'($urandom);
      wr_addr = 12'($urandom); rd_addr = 12'($urandom);
      init_bank = 2'($urandom); aref_bank = 2'($urandom);
      wr_bank = 2'($urandom); rd_bank = 2'($urandom);
      wr_sdram_en = $urandom_range(0, 1); wr_sdram_data = 16'($urandom);
      tick();
      n_vec++;
      if ({aref_en, wr_en, rd_en} !== {m_owner == OWN_AREF, m_owner == OWN_WR, m_owner == OWN_RD}) begin
        n_err++; $display("FAIL rand_grant[%0d]: got %b want owner %0d", c,
                          {aref_en, wr_en, rd_en}, m_owner);
      end
      n_vec++;
      if ({sdram_cmd, sdram_addr, sdram_ba} !== {m_cmd, m_addr, m_ba}) begin
        n_err++; $display("FAIL rand_pins[%0d]: got %b/%h/%b want %b/%h/%b", c,
                          sdram_cmd, sdram_addr, sdram_ba, m_cmd, m_addr, m_ba);
      end
      n_vec++;
      if ({sdram_dq_oe, sdram_dq_out} !== {m_oe, m_dq} || sdram_cke !== 1'b1) begin
        n_err++; $display("FAIL rand_dq[%0d]: got oe=%b dq=%h cke=%b want %b %h 1", c,
                          sdram_dq_oe, sdram_dq_out, sdram_cke, m_oe, m_dq);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_priority();
    test_no_preempt();
    test_reset_mid_write();
    test_wr_rd_alternation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
